// File: rtl/code_lock.sv
// Multi-digit access-code lock with failure alarm and timed lockout.
// Optional auto-relock from OPEN when CODE_LOCK_AUTORELOCK_EN is defined.
module code_lock #(
    parameter int                            DIGIT_W        = 4,
    parameter int                            CODE_LEN       = 4,
    parameter logic [DIGIT_W*CODE_LEN-1:0]   CODE           = 16'h1234,
    parameter int                            MAX_FAILS      = 3,
    parameter int                            LOCKOUT_CYCLES = 1000,
    parameter int                            RELOCK_CYCLES  = 500,
    localparam int                           CW             = $clog2(CODE_LEN + 1),
    localparam int                           FW             = $clog2(MAX_FAILS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               lock_cmd,
    output logic               unlocked,
    output logic               alarm,
    output logic               lockout,
    output logic [FW-1:0]      fail_cnt,
    output logic [CW-1:0]      digit_cnt
);

    localparam int TMAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LAST_IDX  = CW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LIM  = FW'(MAX_FAILS);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] T_ONE     = TW'(1);
`ifdef CODE_LOCK_AUTORELOCK_EN
    localparam logic [TW-1:0] RELOCK_LOAD = TW'(RELOCK_CYCLES);
`endif

    typedef enum logic [1:0] {
        S_ENTRY,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t          state_q;
    logic            mismatch_q;
    logic [TW-1:0]   timer_q;
    logic            unlocked_q;
    logic            alarm_q;
    logic            lockout_q;
    logic [FW-1:0]   fail_q;
    logic [CW-1:0]   dcnt_q;

    // Index 0 selects the most-significant digit of CODE (first one typed).
    function automatic logic [DIGIT_W-1:0] code_digit(input logic [CW-1:0] idx);
        logic [DIGIT_W*CODE_LEN-1:0] sh;
        sh = CODE << (int'(idx) * DIGIT_W);
        return sh[DIGIT_W*CODE_LEN-1 -: DIGIT_W];
    endfunction

    logic          digit_ok;
    logic          entry_good;
    logic [FW-1:0] fail_inc;

    assign digit_ok   = (digit_in == code_digit(dcnt_q));
    assign entry_good = !mismatch_q && digit_ok;
    assign fail_inc   = fail_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_ENTRY;
            mismatch_q <= 1'b0;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            lockout_q  <= 1'b0;
            fail_q     <= '0;
            dcnt_q     <= '0;
        end else begin
            alarm_q <= 1'b0;
            case (state_q)
                S_ENTRY: begin
                    if (digit_valid) begin
                        if (dcnt_q == LAST_IDX) begin
                            dcnt_q     <= '0;
                            mismatch_q <= 1'b0;
                            if (entry_good) begin
                                state_q    <= S_OPEN;
                                unlocked_q <= 1'b1;
                                fail_q     <= '0;
`ifdef CODE_LOCK_AUTORELOCK_EN
                                timer_q    <= RELOCK_LOAD;
`endif
                            end else begin
                                alarm_q <= 1'b1;
                                fail_q  <= fail_inc;
                                if (fail_inc == FAIL_LIM) begin
                                    state_q   <= S_LOCKOUT;
                                    lockout_q <= 1'b1;
                                    timer_q   <= LOCK_LOAD;
                                end
                            end
                        end else begin
                            dcnt_q <= dcnt_q + 1'b1;
                            if (!digit_ok) begin
                                mismatch_q <= 1'b1;
                            end
                        end
                    end
                end
                S_OPEN: begin
`ifdef CODE_LOCK_AUTORELOCK_EN
                    // Relock request and timer expiry in the same cycle collapse into one exit.
                    if (lock_cmd || timer_q <= T_ONE) begin
                        state_q    <= S_ENTRY;
                        unlocked_q <= 1'b0;
                        timer_q    <= '0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
`else
                    if (lock_cmd) begin
                        state_q    <= S_ENTRY;
                        unlocked_q <= 1'b0;
                    end
`endif
                end
                S_LOCKOUT: begin
                    // Exit on the edge where the timer would reach zero, giving exactly LOCKOUT_CYCLES high cycles.
                    if (timer_q <= T_ONE) begin
                        state_q   <= S_ENTRY;
                        lockout_q <= 1'b0;
                        fail_q    <= '0;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_ENTRY;
                end
            endcase
        end
    end

    assign unlocked  = unlocked_q;
    assign alarm     = alarm_q;
    assign lockout   = lockout_q;
    assign fail_cnt  = fail_q;
    assign digit_cnt = dcnt_q;

endmodule

// File: tb/tb_code_lock.sv
// Directed self-checking bench for code_lock (default and 8-bit/2-digit configurations).
// Relock expectations follow CODE_LOCK_AUTORELOCK_EN when the bench is built with it.
module tb_code_lock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       dv;
    logic [3:0] din;
    logic       lock_cmd;
    logic       unlocked, alarm, lockout;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;

    logic       dv2;
    logic [7:0] din2;
    logic       lock2;
    logic       unl2, alarm2, lockout2;
    logic [0:0] fail2;
    logic [1:0] dcnt2;

    code_lock u_dut (
        .clk(clk), .reset(reset), .digit_valid(dv), .digit_in(din), .lock_cmd(lock_cmd),
        .unlocked(unlocked), .alarm(alarm), .lockout(lockout),
        .fail_cnt(fail_cnt), .digit_cnt(digit_cnt)
    );

    code_lock #(
        .DIGIT_W(8), .CODE_LEN(2), .CODE(16'hA55A), .MAX_FAILS(1), .LOCKOUT_CYCLES(20)
    ) u_dut2 (
        .clk(clk), .reset(reset), .digit_valid(dv2), .digit_in(din2), .lock_cmd(lock2),
        .unlocked(unl2), .alarm(alarm2), .lockout(lockout2),
        .fail_cnt(fail2), .digit_cnt(dcnt2)
    );

    int tests = 0;
    int fails = 0;
    int lock_hi = 0;
    int alarm_n = 0;
    int unl_hi = 0;

    always @(posedge clk) begin
        if (lockout)  lock_hi++;
        if (alarm)    alarm_n++;
        if (unlocked) unl_hi++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        dv  = 1'b1;
        din = d;
        step();
        dv  = 1'b0;
    endtask

    task automatic send2(input logic [7:0] d);
        dv2  = 1'b1;
        din2 = d;
        step();
        dv2  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_lock;
        int base_alarm;
        int base_unl;
        int w;

        reset = 1'b1; dv = 1'b0; din = '0; lock_cmd = 1'b0;
        dv2 = 1'b0; din2 = '0; lock2 = 1'b0;
        step(); step();
        check("rst_unlocked", 32'(unlocked), 0);
        check("rst_alarm", 32'(alarm), 0);
        check("rst_lockout", 32'(lockout), 0);
        check("rst_fail", 32'(fail_cnt), 0);
        check("rst_dcnt", 32'(digit_cnt), 0);
        reset = 1'b0;
        step();

        // Correct code
        base_alarm = alarm_n;
        send(4'h1); check("dcnt1", 32'(digit_cnt), 1);
        send(4'h2); check("dcnt2", 32'(digit_cnt), 2);
        send(4'h3); check("dcnt3", 32'(digit_cnt), 3);
        check("unl_before_last", 32'(unlocked), 0);
        send(4'h4);
        check("unl_ok", 32'(unlocked), 1);
        check("dcnt_ok", 32'(digit_cnt), 0);
        check("fail_ok", 32'(fail_cnt), 0);
        check("no_alarm_ok", 32'(alarm_n - base_alarm), 0);
        lock_cmd = 1'b1; step(); lock_cmd = 1'b0;
        check("relock", 32'(unlocked), 0);

        // Single wrong digit, no early rejection
        send(4'h1); send(4'h2); send(4'h9);
        check("no_early_alarm", 32'(alarm), 0);
        check("dcnt_after_9", 32'(digit_cnt), 3);
        send(4'h4);
        check("alarm_pulse", 32'(alarm), 1);
        check("fail_1", 32'(fail_cnt), 1);
        check("unl_wrong", 32'(unlocked), 0);
        check("dcnt_wrong", 32'(digit_cnt), 0);
        step();
        check("alarm_one_cycle", 32'(alarm), 0);
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        check("unl_after_retry", 32'(unlocked), 1);
        check("fail_cleared", 32'(fail_cnt), 0);
        lock_cmd = 1'b1; step(); lock_cmd = 1'b0;

        // Three failures into lockout
        base_lock = lock_hi;
        base_alarm = alarm_n;
        for (int e = 0; e < 3; e++) begin
            for (int k = 0; k < 4; k++) send(4'h5);
            check("fail_alarm", 32'(alarm), 1);
            check("fail_cnt_n", 32'(fail_cnt), 32'(e + 1));
            check("lockout_n", 32'(lockout), (e == 2) ? 1 : 0);
        end
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        check("lk_unl", 32'(unlocked), 0);
        check("lk_dcnt", 32'(digit_cnt), 0);
        check("lk_fail_hold", 32'(fail_cnt), 3);
        w = 0;
        while (lockout === 1'b1 && w < 3000) begin
            step();
            w++;
        end
        check("lockout_fell", 32'(lockout), 0);
        check("lockout_len", 32'(lock_hi - base_lock), 1000);
        check("alarm_count3", 32'(alarm_n - base_alarm), 3);
        check("fail_after_lk", 32'(fail_cnt), 0);
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        check("unl_after_lk", 32'(unlocked), 1);
        lock_cmd = 1'b1; step(); lock_cmd = 1'b0;

        // Hold OPEN for 2000 cycles
        send(4'h1); send(4'h2); send(4'h3);
        base_unl = unl_hi;
        send(4'h4);
        for (int i = 0; i < 2000; i++) step();
`ifdef CODE_LOCK_AUTORELOCK_EN
        check("autorelock_len", 32'(unl_hi - base_unl), 500);
        check("autorelock_unl", 32'(unlocked), 0);
`else
        check("hold_len", 32'(unl_hi - base_unl), 2000);
        check("hold_unl", 32'(unlocked), 1);
`endif
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        check("open_unl", 32'(unlocked), 1);
        check("open_dcnt", 32'(digit_cnt), 0);
        for (int i = 0; i < 9; i++) step();
        lock_cmd = 1'b1; dv = 1'b1; din = 4'h1;
        step();
        lock_cmd = 1'b0; dv = 1'b0;
        check("lockcmd_unl", 32'(unlocked), 0);
        check("lockcmd_dcnt", 32'(digit_cnt), 0);
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        check("unl_after_lockcmd", 32'(unlocked), 1);
        lock_cmd = 1'b1; step(); lock_cmd = 1'b0;

        // Reset mid-entry
        send(4'h1); send(4'h2);
        check("mid_dcnt", 32'(digit_cnt), 2);
        reset = 1'b1; #1;
        check("mid_rst_dcnt", 32'(digit_cnt), 0);
        check("mid_rst_unl", 32'(unlocked), 0);
        step(); reset = 1'b0; step();

        // Reset mid-lockout
        for (int e = 0; e < 3; e++)
            for (int k = 0; k < 4; k++) send(4'h5);
        for (int i = 0; i < 10; i++) step();
        check("pre_rst_lockout", 32'(lockout), 1);
        reset = 1'b1; #1;
        check("lk_rst_lockout", 32'(lockout), 0);
        check("lk_rst_fail", 32'(fail_cnt), 0);
        check("lk_rst_alarm", 32'(alarm), 0);
        check("lk_rst_dcnt", 32'(digit_cnt), 0);
        step(); reset = 1'b0; step();
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        check("unl_after_rst", 32'(unlocked), 1);

        // 8-bit, 2-digit, single-failure configuration
        send2(8'hA5);
        check("c2_dcnt1", 32'(dcnt2), 1);
        send2(8'h5A);
        check("c2_unl", 32'(unl2), 1);
        check("c2_no_alarm", 32'(alarm2), 0);
        lock2 = 1'b1; step(); lock2 = 1'b0;
        check("c2_relock", 32'(unl2), 0);
        send2(8'hA5); send2(8'h00);
        check("c2_alarm", 32'(alarm2), 1);
        check("c2_lockout", 32'(lockout2), 1);
        check("c2_fail", 32'(fail2), 1);
        check("c2_unl_fail", 32'(unl2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/code_lock.md
# code_lock

Parametrised successor to the single-bit sequence lock: accepts a multi-digit access code one digit per valid strobe, unlocks on a full correct entry, pulses an alarm on each failed entry, and enters a timed lockout after a configurable number of consecutive failures. It sits between the keypad/digit front end and the door actuator and alarm logic, on the system clock domain.

## Interface

- DIGIT_W, 4, width of one code digit
- CODE_LEN, 4, digits per code (≥1)
- CODE, 16'h1234, secret code, DIGIT_W*CODE_LEN bits; first digit entered = most-significant digit
- MAX_FAILS, 3, consecutive failed entries that trigger lockout (≥1)
- LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (≥1)
- RELOCK_CYCLES, 500, auto-relock time in clk cycles (≥1; used only with CODE_LOCK_AUTORELOCK_EN)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- digit_valid  input  1  digit_in is valid this cycle
- digit_in  input  DIGIT_W  entered digit
- lock_cmd  input  1  relock request, honoured only in OPEN
- unlocked  output  1  level, high while in OPEN
- alarm  output  1  one-cycle pulse per failed entry
- lockout  output  1  level, high while in LOCKOUT
- fail_cnt  output  $clog2(MAX_FAILS+1)  consecutive failed entries
- digit_cnt  output  $clog2(CODE_LEN+1)  digits accepted in current entry

## Operation

- States: ENTRY, OPEN, LOCKOUT. Reset (async) → ENTRY; all outputs 0, digit_cnt 0, fail_cnt 0, mismatch flag 0, timer 0.
- ENTRY: each digit_valid compares digit_in against CODE digit at index digit_cnt (index 0 = MS digit); mismatch sets a sticky mismatch flag; digit_cnt increments. No early rejection: all CODE_LEN digits are always collected.
- On the CODE_LEN-th accepted digit: digit_cnt → 0, mismatch flag → 0.
  - All digits matched: → OPEN, fail_cnt → 0.
  - Otherwise: alarm pulse; fail_cnt += 1; if new fail_cnt == MAX_FAILS → LOCKOUT, timer loaded with LOCKOUT_CYCLES, else stay in ENTRY.
- OPEN: digit_valid ignored (digit_cnt stays 0). lock_cmd → ENTRY.
- LOCKOUT: digit_valid and lock_cmd ignored; fail_cnt holds MAX_FAILS; timer decrements each cycle; at expiry → ENTRY, fail_cnt → 0.
- lock_cmd outside OPEN: no effect.
- All outputs registered; no combinational input-to-output path.
- Timer width: $clog2(max(LOCKOUT_CYCLES, RELOCK_CYCLES)+1); no wrap, stops at 0.

## Timing

- Digit sampled on the rising edge where digit_valid=1; digit_cnt reflects it from the next cycle.
- unlocked rises the cycle after the edge sampling the final correct digit.
- alarm high for exactly one cycle, in the cycle after the edge sampling the final digit of a failed entry. Failed entries on consecutive final digits give distinct pulses.
- lockout rises in the same cycle as the alarm pulse of the MAX_FAILS-th failure; high for exactly LOCKOUT_CYCLES cycles. A digit_valid in the first cycle after lockout falls is accepted as digit 0.
- lock_cmd sampled at edge N: unlocked low from cycle N+1. A digit_valid at edge N is ignored; the next digit_valid is digit 0.
- Reset asserted mid-entry, in OPEN or in LOCKOUT: immediate return to reset values, no alarm pulse.

## Configuration

- CODE_LOCK_AUTORELOCK_EN defined: entering OPEN loads timer with RELOCK_CYCLES; unlocked stays high for exactly RELOCK_CYCLES cycles, then → ENTRY, unless lock_cmd relocks earlier. lock_cmd at the expiry cycle: single return to ENTRY.
- Not defined: OPEN held indefinitely until lock_cmd; RELOCK_CYCLES unused.

## Test plan

- Reset, then digits 1,2,3,4 on consecutive cycles → unlocked=1 one cycle after 4th digit, alarm never high, fail_cnt=0, digit_cnt=0.
- Digits 1,2,9,4 → no early reaction after 9; alarm single-cycle pulse after 4th digit, fail_cnt=1, unlocked=0; then 1,2,3,4 → unlocked=1, fail_cnt=0.
- Three wrong entries (5,5,5,5 ×3) → three alarm pulses, lockout=1 with 3rd pulse for exactly 1000 cycles; 1,2,3,4 during lockout → unlocked stays 0; after lockout fail_cnt=0 and 1,2,3,4 unlocks.
- Unlock, hold lock_cmd=0 for 2000 cycles → without macro unlocked stays 1; with CODE_LOCK_AUTORELOCK_EN unlocked falls after exactly 500 cycles. Pulse lock_cmd together with digit_valid at cycle 10 → unlocked=0 next cycle, digit_cnt=0.
- Reset asserted after 2 digits, and again mid-lockout → all outputs 0 immediately, digit_cnt=0, fail_cnt=0; subsequent 1,2,3,4 unlocks.
- Reconfigure DIGIT_W=8, CODE_LEN=2, CODE=16'hA55A, MAX_FAILS=1 → A5,5A unlocks; A5,00 → alarm and lockout in the same cycle.
